// File: rtl/grid_coord_gen_pkg.sv
// Shared definitions for the heat-map grid sweep: FSM state encodings and the
// default grid geometry used by the memory reader, this generator and the VGA engine.
package grid_coord_gen_pkg;

    // FSM state encodings (kept as plain constants so legacy blocks can share them)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default grid geometry
    localparam int DEF_N_X      = 41;
    localparam int DEF_N_Y      = 41;
    localparam int DEF_IDX_W    = 6;
    localparam int DEF_PIX_W    = 10;
    localparam int DEF_X_PITCH  = 1;
    localparam int DEF_Y_PITCH  = 1;
    localparam int DEF_X_ORIGIN = 0;
    localparam int DEF_Y_ORIGIN = 0;

endpackage

// File: rtl/grid_coord_gen_axis_counter.sv
// One axis of the grid sweep: a cell index plus a pixel accumulator that
// tracks ORIGIN + (idx+1)*PITCH without a multiplier.
module axis_counter #(
    parameter int N      = 41,
    parameter int IDX_W  = 6,
    parameter int PIX_W  = 10,
    parameter int PITCH  = 1,
    parameter int ORIGIN = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             adv,
    output logic [IDX_W-1:0] idx,
    output logic [PIX_W-1:0] pix,
    output logic             at_max
);

    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N - 1);
    localparam logic [PIX_W-1:0] PIX_FIRST = PIX_W'(ORIGIN + PITCH);
    localparam logic [PIX_W-1:0] PIX_STEP  = PIX_W'(PITCH);

    // The largest coordinate ever produced must fit in PIX_W bits, and every
    // index must fit in IDX_W bits.
    generate
        if (ORIGIN + N * PITCH >= (1 << PIX_W)) begin : g_pix_range_err
            $error("axis_counter: ORIGIN + N*PITCH does not fit in PIX_W bits");
        end
        if (N < 1 || N > (1 << IDX_W)) begin : g_idx_range_err
            $error("axis_counter: N must be in 1..2**IDX_W");
        end
    endgenerate

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    assign at_max = (idx_q == IDX_MAX);
    assign idx    = idx_q;
    assign pix    = pix_q;

    // Next index/pixel: reload at the first cell on load or wrap, else step by one cell
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        idx_d = idx_q;
        pix_d = pix_q;
        if (load || (adv && at_max)) begin
            idx_d = '0;
            pix_d = PIX_FIRST;
        end else if (adv) begin
            idx_d = idx_q + IDX_W'(1);
            pix_d = pix_q + PIX_STEP;
        end
    end

    // Axis state registers, cleared by reset so no partial-frame position survives
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            idx_q <= '0;
            pix_q <= '0;
        end else begin
            idx_q <= idx_d;
            pix_q <= pix_d;
        end
    end

endmodule

// File: rtl/grid_coord_gen.sv
// Row-major sweep over an N_X x N_Y heat-map grid. Emits each cell index with
// its VGA pixel coordinate on a valid/ready stream, one frame per start pulse.
module grid_coord_gen
    import grid_coord_gen_pkg::*;
#(
    parameter int N_X      = DEF_N_X,
    parameter int N_Y      = DEF_N_Y,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int X_PITCH  = DEF_X_PITCH,
    parameter int Y_PITCH  = DEF_Y_PITCH,
    parameter int X_ORIGIN = DEF_X_ORIGIN,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] cell_i,
    output logic [IDX_W-1:0] cell_j,
    output logic [PIX_W-1:0] pix_x,
    output logic [PIX_W-1:0] pix_y,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    logic [1:0] state_q, state_d;
    logic       x_at_max, y_at_max;
    logic       load, hs, adv_x, adv_y;

    // A new frame is loaded only from IDLE, and abort always takes priority.
    assign load  = (state_q == ST_IDLE) && start && !abort;
    assign hs    = out_valid && out_ready;
    // The final cell never advances, so the counters do not wrap past the frame end.
    assign adv_x = hs && !out_last && !abort;
    assign adv_y = adv_x && x_at_max;

    assign out_valid = (state_q == ST_RUN);
    assign out_last  = out_valid && x_at_max && y_at_max;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    axis_counter #(
        .N(N_X), .IDX_W(IDX_W), .PIX_W(PIX_W), .PITCH(X_PITCH), .ORIGIN(X_ORIGIN)
    ) u_x (
        .clk(clk), .reset_n(reset_n), .load(load), .adv(adv_x),
        .idx(cell_i), .pix(pix_x), .at_max(x_at_max)
    );

    axis_counter #(
        .N(N_Y), .IDX_W(IDX_W), .PIX_W(PIX_W), .PITCH(Y_PITCH), .ORIGIN(Y_ORIGIN)
    ) u_y (
        .clk(clk), .reset_n(reset_n), .load(load), .adv(adv_y),
        .idx(cell_j), .pix(pix_y), .at_max(y_at_max)
    );

    // Sweep FSM: IDLE -> RUN on start, RUN -> DONE on the last handshake, abort returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && !abort) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)              state_d = ST_IDLE;
                else if (hs && out_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

endmodule

// File: tb/tb_grid_coord_gen.sv
// Directed bench for grid_coord_gen: default 41x41 sweep, offset/pitch variant,
// stall, abort, reset mid-frame, start during RUN and the 1x1 degenerate grid.
module tb_grid_coord_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: defaults
    logic       a_start = 0, a_abort = 0, a_ready = 0;
    logic       a_valid, a_last, a_busy, a_done;
    logic [5:0] a_i, a_j;
    logic [9:0] a_px, a_py;

    // Instance B: X_PITCH=12, X_ORIGIN=16
    logic       b_start = 0, b_abort = 0, b_ready = 0;
    logic       b_valid, b_last, b_busy, b_done;
    logic [5:0] b_i, b_j;
    logic [9:0] b_px, b_py;

    // Instance C: 1x1 grid
    logic       c_start = 0, c_abort = 0, c_ready = 0;
    logic       c_valid, c_last, c_busy, c_done;
    logic [5:0] c_i, c_j;
    logic [9:0] c_px, c_py;

    grid_coord_gen u_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort), .out_ready(a_ready),
        .out_valid(a_valid), .cell_i(a_i), .cell_j(a_j), .pix_x(a_px), .pix_y(a_py),
        .out_last(a_last), .busy(a_busy), .done(a_done)
    );

    grid_coord_gen #(.X_PITCH(12), .X_ORIGIN(16)) u_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort), .out_ready(b_ready),
        .out_valid(b_valid), .cell_i(b_i), .cell_j(b_j), .pix_x(b_px), .pix_y(b_py),
        .out_last(b_last), .busy(b_busy), .done(b_done)
    );

    grid_coord_gen #(.N_X(1), .N_Y(1)) u_c (
        .clk(clk), .reset_n(reset_n), .start(c_start), .abort(c_abort), .out_ready(c_ready),
        .out_valid(c_valid), .cell_i(c_i), .cell_j(c_j), .pix_x(c_px), .pix_y(c_py),
        .out_last(c_last), .busy(c_busy), .done(c_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_beat(input string tag, input int ei, input int ej, input logic el);
        check({tag, ".valid"}, 32'(a_valid), 32'd1);
        check({tag, ".i"},     32'(a_i),     32'(ei));
        check({tag, ".j"},     32'(a_j),     32'(ej));
        check({tag, ".pix_x"}, 32'(a_px),    32'(ei + 1));
        check({tag, ".pix_y"}, 32'(a_py),    32'(ej + 1));
        check({tag, ".last"},  32'(a_last),  32'(el));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.valid", 32'(a_valid), 0);
        check("rst.busy",  32'(a_busy),  0);
        check("rst.done",  32'(a_done),  0);
        check("rst.last",  32'(a_last),  0);
        check("rst.pix_x", 32'(a_px),    0);
        check("rst.cell_i", 32'(a_i),    0);
        #10 reset_n = 1'b1;
        tick();

        // 1. Full default sweep with out_ready held high
        a_start = 1; a_ready = 1;
        tick();
        a_start = 0;
        for (int k = 0; k < 41 * 41; k++) begin
            check_a_beat("sweep", k % 41, k / 41, k == 41 * 41 - 1);
            tick();
        end
        check("sweep.done",       32'(a_done),  1);
        check("sweep.done_valid", 32'(a_valid), 0);
        tick();
        check("sweep.done_clr", 32'(a_done), 0);
        check("sweep.idle",     32'(a_busy), 0);

        // 3. Stall at (7,2)
        a_start = 1;
        tick();
        a_start = 0;
        for (int k = 0; k < 2 * 41 + 7; k++) tick();
        check_a_beat("pre_stall", 7, 2, 0);
        a_ready = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_a_beat("stall", 7, 2, 0);
        end
        a_ready = 1;
        tick();
        check_a_beat("resume", 8, 2, 0);

        // 4. Abort while stalled at (20,10)
        for (int k = 2 * 41 + 8; k < 10 * 41 + 20; k++) tick();
        a_ready = 0;
        tick();
        check_a_beat("pre_abort", 20, 10, 0);
        a_abort = 1;
        tick();
        a_abort = 0;
        check("abort.valid", 32'(a_valid), 0);
        check("abort.busy",  32'(a_busy),  0);
        check("abort.done",  32'(a_done),  0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("abort.no_done", 32'(a_done), 0);
        end
        a_start = 1; a_abort = 1;
        tick();
        a_start = 0; a_abort = 0;
        check("start_abort.busy",  32'(a_busy),  0);
        check("start_abort.valid", 32'(a_valid), 0);
        tick();
        check("start_abort.busy2", 32'(a_busy), 0);

        // 6a. start pulsed during RUN leaves the sequence alone
        a_ready = 1; a_start = 1;
        tick();
        a_start = 0;
        for (int k = 0; k < 8; k++) begin
            check_a_beat("start_in_run", k, 0, 0);
            a_start = (k == 3);
            tick();
        end
        a_start = 0;

        // 5. Reset mid-sweep at (5,5)
        for (int k = 8; k < 5 * 41 + 5; k++) tick();
        check_a_beat("pre_reset", 5, 5, 0);
        reset_n = 0;
        #1;
        check("reset.valid", 32'(a_valid), 0);
        check("reset.busy",  32'(a_busy),  0);
        check("reset.i",     32'(a_i),     0);
        check("reset.j",     32'(a_j),     0);
        check("reset.pix_x", 32'(a_px),    0);
        check("reset.pix_y", 32'(a_py),    0);
        tick();
        reset_n = 1;
        tick();
        check("post_reset.busy", 32'(a_busy), 0);
        a_start = 1;
        tick();
        a_start = 0;
        check_a_beat("restart", 0, 0, 0);
        a_abort = 1;
        tick();
        a_abort = 0;

        // 2. Pitch/origin variant
        b_start = 1; b_ready = 1;
        tick();
        b_start = 0;
        for (int k = 0; k <= 41; k++) begin
            if (k == 0) check("pitch.i0_pix_x", 32'(b_px), 28);
            if (k == 3) check("pitch.i3_pix_x", 32'(b_px), 64);
            if (k == 40) begin
                check("pitch.i40_pix_x", 32'(b_px), 508);
                check("pitch.i40_pix_y", 32'(b_py), 1);
            end
            if (k == 41) begin
                check("pitch.wrap_i",     32'(b_i),  0);
                check("pitch.wrap_j",     32'(b_j),  1);
                check("pitch.wrap_pix_x", 32'(b_px), 28);
                check("pitch.wrap_pix_y", 32'(b_py), 2);
            end
            tick();
        end
        b_abort = 1;
        tick();
        b_abort = 0;
        check("pitch.abort_busy", 32'(b_busy), 0);

        // 6b. Degenerate 1x1 grid
        c_start = 1; c_ready = 1;
        tick();
        c_start = 0;
        check("one.valid", 32'(c_valid), 1);
        check("one.last",  32'(c_last),  1);
        check("one.i",     32'(c_i),     0);
        check("one.pix_x", 32'(c_px),    1);
        check("one.pix_y", 32'(c_py),    1);
        tick();
        check("one.valid_off", 32'(c_valid), 0);
        check("one.done",      32'(c_done),  1);
        tick();
        check("one.done_clr", 32'(c_done), 0);
        check("one.idle",     32'(c_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
